// File: rtl/cic_comp_fir.sv
// cic_comp_fir: time-multiplexed symmetric FIR that flattens the CIC sinc droop on the decimated stream
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         busy,
  output logic                         overrun
);
  localparam int TW = $clog2(NUM_TAPS);
  localparam int AW = DATA_WIDTH + COEF_WIDTH + TW;
  localparam logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS] = '{
    COEF_WIDTH'(-256), COEF_WIDTH'(512), COEF_WIDTH'(-1024), COEF_WIDTH'(8960),
    COEF_WIDTH'(8960), COEF_WIDTH'(-1024), COEF_WIDTH'(512), COEF_WIDTH'(-256)};
  localparam logic signed [AW-1:0] half = AW'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [AW-1:0] pmax = AW'((64'sd1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] nmin = -pmax - AW'(1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tap;
  logic signed [DATA_WIDTH-1:0] x [NUM_TAPS];
  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
  logic signed [AW-1:0] acc, acc_nx, rnd;
  logic [DATA_WIDTH-1:0] sat;
  logic accept, last;
  always_comb begin
    accept = in_valid && state != MAC;
    last = tap == TW'(NUM_TAPS - 1);
    prod = x[tap] * coef[tap];
    acc_nx = acc + AW'(prod);
    rnd = (acc_nx + half) >>> COEF_FRAC;
    sat = rnd > pmax ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
          rnd < nmin ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : rnd[DATA_WIDTH-1:0];
    state_nx = accept ? MAC : state == MAC ? (last ? OUT : MAC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // The final tap's sum is rounded straight into data_out so out_valid lands in the OUT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '{default: '0};
      acc <= '0;
      tap <= '0;
      data_out <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= state == MAC && last;
      busy <= state_nx == MAC;
      overrun <= overrun | (in_valid && state == MAC);
      if (state == MAC) begin
        acc <= acc_nx;
        tap <= tap + 1'b1;
      end
      if (state == MAC && last) data_out <= sat;
      if (accept) begin
        x[0] <= data_in;
        for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
        acc <= '0;
        tap <= '0;
      end
    end
  end
endmodule
